hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage RV32I core (F/D/E/M/W).
- Produces per-stage stall/flush controls for load-use hazards, taken branches and jumps, and multi-cycle data-memory accesses.
- Selects E-stage operand forwarding paths.
- Runs a memory-wait FSM with timeout and keeps performance counters. Sits beside the decode ControlUnit and consumes pipelined control bits plus the data-memory handshake.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/forward_unit.sv | 21 ++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline hazard controller.
package riscv_pkg;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hazard_state_t;

  // M has priority over W because it holds the younger result; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       reg_write_m,
    input logic [4:0] rd_w,
    input logic       reg_write_w
  );
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_W;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/forward_unit.sv
// E-stage operand forwarding select for both ALU sources.
module forward_unit
  import riscv_pkg::*;
(
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e
);

  // Both selects are pure functions of the current M/W writeback state.
  always_comb begin
    forward_a_e = fwd_select(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    forward_b_e = fwd_select(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush generation, data-memory wait FSM with
// timeout, and stall/flush performance counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal flow; load-use / redirect / zero-wait memory handled
//   MEM_WAIT | data memory busy; whole pipe frozen, W bubbled
//   ERR      | memory timed out; pipe frozen until reset
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [1:0]       result_src_e,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_w,
  input  logic             pc_src_e,
  input  logic             mem_op_m,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int              WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  hazard_state_t     state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic load_use;
  logic mem_stall;
  logic redirect;
  logic any_stall;

  forward_unit u_forward_unit (
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e)
  );

  // Next-state, stall/flush outputs and counter updates; reset forces a bubble everywhere.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    mem_req    = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    redirect   = 1'b0;

    load_use  = (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
                ((rd_e == rs1_d) || (rd_e == rs2_d));
    mem_stall = mem_op_m && !mem_ack;

    unique case (state_q)
      RUN: begin
        mem_req = mem_op_m;
        if (mem_stall) begin
          // Freezing the front end drops any coincident hazard; it is re-seen on release.
          {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
          flush_w    = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          // A redirect squashes D, so a load-use stall on it is pointless.
          flush_d  = pc_src_e;
          flush_e  = pc_src_e | load_use;
          stall_f  = load_use & ~pc_src_e;
          stall_d  = load_use & ~pc_src_e;
          redirect = pc_src_e;
        end
      end
      MEM_WAIT: begin
        mem_req = mem_op_m;
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
        if (mem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERR: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst_n) begin
      mem_req  = 1'b0;
      {stall_f, stall_d, stall_e, stall_m} = 4'b0000;
      {flush_d, flush_e, flush_w}          = 3'b111;
      redirect = 1'b0;
    end

    any_stall      = stall_f | stall_d | stall_e | stall_m;
    stall_cycles_d = stall_cycles_q + CNT_W'(any_stall);
    flush_count_d  = flush_count_q + CNT_W'(redirect);
  end

  // State, wait counter, sticky error and performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors, a cycle-level
// behavioural model checked every cycle, plus hand-computed literal checks.
module tb_hazard_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]       result_src_e;
  logic             reg_write_m, reg_write_w, pc_src_e, mem_op_m, mem_ack;
  logic             mem_req;
  logic [1:0]       forward_a_e, forward_b_e;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .result_src_e (result_src_e),
    .rd_m         (rd_m),
    .reg_write_m  (reg_write_m),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .pc_src_e     (pc_src_e),
    .mem_op_m     (mem_op_m),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_w      (flush_w),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Model: pipe is either running, waiting on memory (with elapsed wait count), or failed.
  bit          m_waiting = 0;
  bit          m_failed  = 0;
  int          m_waited  = 0;
  logic [31:0] m_stalls  = 0;
  logic [31:0] m_flushes = 0;

  // Compare all outputs against the model mid-cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e_st;
      logic [2:0] e_fl;
      logic       e_req;
      logic       lu, br, stall_now;
      lu = (result_src_e == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      br = pc_src_e;
      e_st  = 4'b0000;
      e_fl  = 3'b000;
      e_req = mem_op_m;
      if (!rst_n) begin
        e_fl  = 3'b111;
        e_req = 1'b0;
      end else if (m_failed) begin
        e_st  = 4'b1111;
        e_fl  = 3'b001;
        e_req = 1'b0;
      end else if (m_waiting || (mem_op_m && !mem_ack)) begin
        e_st = 4'b1111;
        e_fl = 3'b001;
      end else begin
        e_fl = {br, br | lu, 1'b0};
        e_st = {lu && !br, lu && !br, 2'b00};
      end

      chk("forward_a_e", 32'(forward_a_e), 32'(fwd_exp(rs1_e)));
      chk("forward_b_e", 32'(forward_b_e), 32'(fwd_exp(rs2_e)));
      chk("stalls_fdem", 32'({stall_f, stall_d, stall_e, stall_m}), 32'(e_st));
      chk("flushes_dew", 32'({flush_d, flush_e, flush_w}), 32'(e_fl));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("mem_err", 32'(mem_err), 32'(m_failed));
      chk("stall_cycles", stall_cycles, m_stalls);
      chk("flush_count", flush_count, m_flushes);

      stall_now = |e_st;
      if (!rst_n) begin
        m_waiting = 0; m_failed = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
      end else begin
        if (stall_now) m_stalls = m_stalls + 1;
        if (m_failed) begin
        end else if (m_waiting) begin
          if (mem_ack) begin
            m_waiting = 0; m_waited = 0;
          end else if (m_waited == TO) begin
            m_waiting = 0; m_failed = 1;
          end else begin
            m_waited++;
          end
        end else if (mem_op_m && !mem_ack) begin
          m_waiting = 1; m_waited = 1;
        end else if (br) begin
          m_flushes = m_flushes + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    result_src_e = 0; reg_write_m = 0; reg_write_w = 0;
    pc_src_e = 0; mem_op_m = 0; mem_ack = 0;
  endtask

  // Forwarding vectors: rs1_e, rs2_e, rd_m, reg_write_m, rd_w, reg_write_w -> fa, fb
  logic [4:0] fv_rs1 [5] = '{5'd3, 5'd3, 5'd0, 5'd9, 5'd12};
  logic [4:0] fv_rs2 [5] = '{5'd4, 5'd3, 5'd0, 5'd9, 5'd13};
  logic [4:0] fv_rdm [5] = '{5'd3, 5'd0, 5'd0, 5'd9, 5'd13};
  logic       fv_wm  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [4:0] fv_rdw [5] = '{5'd4, 5'd3, 5'd0, 5'd9, 5'd12};
  logic       fv_ww  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] fv_ea  [5] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
  logic [1:0] fv_eb  [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10};

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    tick();
    chk_en = 1;
    mid();
    chk("rst_flush_d", 32'(flush_d), 32'd1);
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    tick();

    // Forwarding
    rst_n = 1'b1;
    rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
    mid();
    chk("fwd_m_prio", 32'(forward_a_e), 32'd2);
    reg_write_m = 0;
    #1;
    chk("fwd_w", 32'(forward_a_e), 32'd1);
    rd_m = 0; rs1_e = 0; reg_write_m = 1;
    #1;
    chk("fwd_x0", 32'(forward_a_e), 32'd0);
    chk("cnt_zero_stall", stall_cycles, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      rs1_e = fv_rs1[i]; rs2_e = fv_rs2[i]; rd_m = fv_rdm[i]; reg_write_m = fv_wm[i];
      rd_w = fv_rdw[i]; reg_write_w = fv_ww[i];
      mid();
      chk("fwd_tab_a", 32'(forward_a_e), 32'(fv_ea[i]));
      chk("fwd_tab_b", 32'(forward_b_e), 32'(fv_eb[i]));
      tick();
    end
    clear_inputs();

    // Load-use
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    mid();
    chk("lu_stall_fd", 32'({stall_f, stall_d}), 32'b11);
    chk("lu_flush_e", 32'(flush_e), 32'd1);
    tick();
    clear_inputs();
    mid();
    chk("lu_stall_cnt", stall_cycles, 32'd1);
    chk("lu_released", 32'(stall_f), 32'd0);
    tick();

    // Branch together with load-use
    result_src_e = 2'b01; rd_e = 7; rs1_d = 7; pc_src_e = 1;
    mid();
    chk("br_flush_de", 32'({flush_d, flush_e}), 32'b11);
    chk("br_no_stall_f", 32'(stall_f), 32'd0);
    tick();
    clear_inputs();
    mid();
    chk("br_flush_cnt", flush_count, 32'd1);
    chk("br_stall_cnt", stall_cycles, 32'd1);
    tick();

    // Memory wait: ack low 3 cycles, then high (with a coincident branch suppressed)
    mem_op_m = 1; mem_ack = 0; pc_src_e = 1;
    mid();
    chk("mw_flush_d_supp", 32'(flush_d), 32'd0);
    tick();
    pc_src_e = 0;
    tick();
    tick();
    mem_ack = 1;
    mid();
    chk("mw_ack_stall_m", 32'(stall_m), 32'd1);
    chk("mw_ack_flush_w", 32'(flush_w), 32'd1);
    tick();
    mem_op_m = 0; mem_ack = 0;
    mid();
    chk("mw_run_again", 32'(stall_f), 32'd0);
    chk("mw_stall_cnt", stall_cycles, 32'd5);
    chk("mw_flush_cnt", flush_count, 32'd1);
    tick();
    mem_op_m = 1; mem_ack = 1;
    mid();
    chk("zw_no_stall", 32'(stall_m), 32'd0);
    chk("zw_req", 32'(mem_req), 32'd1);
    tick();

    // Timeout
    mem_ack = 0;
    repeat (4) tick();
    mid();
    chk("to_not_yet", 32'(mem_err), 32'd0);
    tick();
    mid();
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_stalls", 32'({stall_f, stall_d, stall_e, stall_m}), 32'hF);
    tick();
    tick();
    rst_n = 0;
    mid();
    chk("to_rst_flush_w", 32'(flush_w), 32'd1);
    chk("to_rst_stall_f", 32'(stall_f), 32'd0);
    tick();
    rst_n = 1; mem_op_m = 0;
    mid();
    chk("to_rst_err", 32'(mem_err), 32'd0);
    chk("to_rst_cnt", stall_cycles, 32'd0);
    chk("to_rst_fcnt", flush_count, 32'd0);
    tick();

    // Reset mid-wait
    mem_op_m = 1; mem_ack = 0;
    tick();
    tick();
    rst_n = 0;
    mid();
    chk("rmw_flushes", 32'({flush_d, flush_e, flush_w}), 32'b111);
    chk("rmw_stalls", 32'({stall_f, stall_d, stall_e, stall_m}), 32'h0);
    chk("rmw_req", 32'(mem_req), 32'd0);
    tick();
    rst_n = 1; mem_ack = 1;
    mid();
    chk("rmw_zero_wait", 32'(stall_m), 32'd0);
    chk("rmw_req_on", 32'(mem_req), 32'd1);
    tick();
    clear_inputs();
    tick();
    mid();
    chk("rmw_cnt", stall_cycles, 32'd0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
